// File: rtl/striping_pkg.sv
// Definitions shared by demux_striping and mux_striping: stream width,
// lane selector encoding and the number of clk_2f cycles a lane word is held.
package striping_pkg;

    localparam int unsigned DATA_WIDTH_DEFAULT = 32;
    localparam int unsigned HOLD_CYCLES        = 2;

    typedef enum logic {
        EXPECT_L0 = 1'b0,
        EXPECT_L1 = 1'b1
    } sel_t;

endpackage : striping_pkg

// File: rtl/lane_hold_timer.sv
// Down-counter that keeps a lane word valid for HOLD_CYCLES clk_2f cycles.
// expiring flags the edge on which the count reaches zero.
module lane_hold_timer
    import striping_pkg::*;
(
    input  logic clk_2f,
    input  logic reset_L,
    input  logic load,
    output logic expiring
);

    logic [1:0] count;

    always_ff @(posedge clk_2f) begin
        if (!reset_L) begin
            count <= '0;
        end else if (load) begin
            count <= 2'(HOLD_CYCLES);
        end else if (count != '0) begin
            count <= count - 2'd1;
        end
    end

    assign expiring = (count == 2'd1);

endmodule : lane_hold_timer

// File: rtl/demux_striping.sv
// Transmit-side lane splitter: alternates consecutive valid stream words onto
// lane 0 and lane 1, each pair held for one clk_f period (two clk_2f cycles).
module demux_striping
    import striping_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  clk_2f,
    input  logic                  reset_L,
    input  logic [DATA_WIDTH-1:0] data_input,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] lane_0,
    output logic [DATA_WIDTH-1:0] lane_1,
    output logic                  valid_0,
    output logic                  valid_1
);

    sel_t                  sel, sel_next;
    logic [DATA_WIDTH-1:0] hold;
    logic                  accept_l0;
    logic                  load_pair;
    logic                  load_flush;
    logic                  timer_load;
    logic                  expiring;

    always_ff @(posedge clk_2f) begin
        if (!reset_L) begin
            sel <= EXPECT_L0;
        end else begin
            sel <= sel_next;
        end
    end

    always_comb begin
        sel_next   = sel;
        accept_l0  = 1'b0;
        load_pair  = 1'b0;
        load_flush = 1'b0;
        unique case (sel)
            EXPECT_L0: begin
                if (valid_in) begin
                    accept_l0 = 1'b1;
                    sel_next  = EXPECT_L1;
                end
            end
            EXPECT_L1: begin
                // A pending lane-0 word always leaves: paired if a word arrives, flushed alone otherwise.
                if (valid_in) begin
                    load_pair = 1'b1;
                end else begin
                    load_flush = 1'b1;
                end
                sel_next = EXPECT_L0;
            end
            default: sel_next = EXPECT_L0;
        endcase
    end

    assign timer_load = load_pair | load_flush;

    lane_hold_timer u_hold_timer (
        .clk_2f   (clk_2f),
        .reset_L  (reset_L),
        .load     (timer_load),
        .expiring (expiring)
    );

    always_ff @(posedge clk_2f) begin
        if (!reset_L) begin
            hold    <= '0;
            lane_0  <= '0;
            lane_1  <= '0;
            valid_0 <= 1'b0;
            valid_1 <= 1'b0;
        end else begin
            if (accept_l0) begin
                hold <= data_input;
            end
            if (load_pair) begin
                lane_0  <= hold;
                lane_1  <= data_input;
                valid_0 <= 1'b1;
                valid_1 <= 1'b1;
            end else if (load_flush) begin
                lane_0  <= hold;
                lane_1  <= '0;
                valid_0 <= 1'b1;
                valid_1 <= 1'b0;
            end else if (expiring) begin
                // Lane data deliberately keeps its last value; only the valids drop.
                valid_0 <= 1'b0;
                valid_1 <= 1'b0;
            end
        end
    end

endmodule : demux_striping
